// File: rtl/uart_report_formatter_if.sv
// Report request inputs, UART TX handshake and status flags of the report formatter.
// Latency: n/a (signal bundle only).
// Backpressure: tx_busy from the transmitter stalls the formatter between bytes.
interface uart_report_formatter_if;
   logic       report_valid;
   logic       pll_to_update;
   logic [2:0] phasecounterselect_1;
   logic [2:0] phasecounterselect_2;
   logic       phaseupdown;
   logic [7:0] periods_done;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       busy;
   logic       overrun;

   // formatter side
   modport master (
      input  report_valid, pll_to_update, phasecounterselect_1, phasecounterselect_2,
      input  phaseupdown, periods_done, tx_busy,
      output tx_data, tx_start, busy, overrun
   );

   // requester / transmitter side
   modport slave (
      output report_valid, pll_to_update, phasecounterselect_1, phasecounterselect_2,
      output phaseupdown, periods_done, tx_busy,
      input  tx_data, tx_start, busy, overrun
   );
endinterface

// File: rtl/uart_report_formatter.sv
// Encodes executed phase-shift parameters as an ASCII frame (gen, dir, decimal count, 'S') for the UART TX.
// Latency: 1 cycle accept + up to 12 cycles decimal conversion, then one byte per TX start/busy handshake.
// Backpressure: each byte waits for tx_busy low before start; requests arriving while busy are dropped and flagged.
module uart_report_formatter #(
   parameter logic [7:0] BASE           = 8'h30,
   parameter logic [7:0] STOP_CHAR      = 8'h53,
   parameter bit         SUPPRESS_ZEROS = 1'b1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   uart_report_formatter_if.master   rpt
);

   typedef enum logic [2:0] {IDLE, CONVERT, LOAD, WAIT_HI, WAIT_LO} state_t;

   // byte index within the frame: 0 gen, 1 dir, 2 hundreds, 3 tens, 4 ones, 5 stop
   localparam logic [2:0] IDX_STOP = 3'd5;

   state_t     state, state_nxt;
   logic [2:0] idx, idx_nxt;
   logic [7:0] byte_nxt;

   logic       req_prev;
   logic       req_edge;
   logic [2:0] gen_q;
   logic       dir_q;
   logic [7:0] val;       // remainder during conversion, ones digit afterwards
   logic [1:0] hund;
   logic [3:0] tens;
   logic [7:0] tx_data_q;
   logic       tx_start_q;
   logic       busy_q;
   logic       overrun_q;

   assign req_edge     = rpt.report_valid & ~req_prev;
   assign rpt.tx_data  = tx_data_q;
   assign rpt.tx_start = tx_start_q;
   assign rpt.busy     = busy_q;
   assign rpt.overrun  = overrun_q;

   // state and byte index register; the whole block runs on the falling edge like the receive path
   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         idx   <= 3'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // next state, next byte index (with leading-zero skipping) and the byte to present in LOAD
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      byte_nxt  = STOP_CHAR;
      case (state)
         IDLE:    if (req_edge) state_nxt = CONVERT;
         CONVERT: if (val < 8'd10) begin
                     state_nxt = LOAD;
                     idx_nxt   = 3'd0;
                  end
         LOAD:    if (!rpt.tx_busy) state_nxt = WAIT_HI;
         WAIT_HI: if (rpt.tx_busy) state_nxt = WAIT_LO;
         WAIT_LO: if (!rpt.tx_busy) begin
                     if (idx == IDX_STOP) begin
                        state_nxt = IDLE;
                     end else begin
                        state_nxt = LOAD;
                        idx_nxt   = idx + 3'd1;
                        if (SUPPRESS_ZEROS && idx_nxt == 3'd2 && hund == 2'd0)
                           idx_nxt = 3'd3;
                        if (SUPPRESS_ZEROS && idx_nxt == 3'd3 && hund == 2'd0 && tens == 4'd0)
                           idx_nxt = 3'd4;
                     end
                  end
         default: state_nxt = IDLE;
      endcase
      case (idx_nxt)
         3'd0:    byte_nxt = BASE + {5'b0, gen_q};
         3'd1:    byte_nxt = BASE + {7'b0, dir_q};
         3'd2:    byte_nxt = BASE + {6'b0, hund};
         3'd3:    byte_nxt = BASE + {4'b0, tens};
         3'd4:    byte_nxt = BASE + {4'b0, val[3:0]};
         default: byte_nxt = STOP_CHAR;
      endcase
   end

   // request latching, repeated-subtraction conversion, TX data/strobe and status flags
   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_prev   <= 1'b0;
         gen_q      <= 3'd0;
         dir_q      <= 1'b0;
         val        <= 8'd0;
         hund       <= 2'd0;
         tens       <= 4'd0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         req_prev   <= rpt.report_valid;
         tx_start_q <= (state == LOAD) && !rpt.tx_busy;
         // busy_q is still high in the cycle it falls, so a coincident edge counts as overrun
         if (req_edge && busy_q)
            overrun_q <= 1'b1;
         case (state)
            IDLE: if (req_edge) begin
                     // generator number is the inverse of the command mapper's select mapping
                     gen_q  <= rpt.pll_to_update ? rpt.phasecounterselect_2 + 3'd2
                                                 : rpt.phasecounterselect_1 - 3'd2;
                     dir_q  <= rpt.phaseupdown;
                     val    <= rpt.periods_done;
                     hund   <= 2'd0;
                     tens   <= 4'd0;
                     busy_q <= 1'b1;
                  end
            CONVERT: if (val >= 8'd100) begin
                        val  <= val - 8'd100;
                        hund <= hund + 2'd1;
                     end else if (val >= 8'd10) begin
                        val  <= val - 8'd10;
                        tens <= tens + 4'd1;
                     end
            WAIT_LO: if (!rpt.tx_busy && idx == IDX_STOP)
                        busy_q <= 1'b0;
            default: ;
         endcase
         // data changes only when a new byte is loaded, so it holds across the whole handshake
         if (state_nxt == LOAD)
            tx_data_q <= byte_nxt;
      end
   end

endmodule

// File: tb/tb_uart_report_formatter.sv
// Scoreboard bench: two formatters (leading zeros suppressed / full 3 digits) share request stimulus.
// Latency: n/a.
// Backpressure: a behavioural TX model per instance drives tx_busy for a programmable number of cycles.
module tb_uart_report_formatter;

   localparam logic [7:0] BASE = 8'h30;
   localparam logic [7:0] STOP = 8'h53;

   logic clk;
   logic rst_n;

   uart_report_formatter_if rif0 ();
   uart_report_formatter_if rif1 ();

   uart_report_formatter #(.SUPPRESS_ZEROS(1'b1)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .rpt(rif0));
   uart_report_formatter #(.SUPPRESS_ZEROS(1'b0)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .rpt(rif1));

   int         total = 0;
   int         bad   = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic       hold;        // forces tx_busy high on both transmitters
   int         busy_len;    // 0 = random 1..4 per byte
   logic       mb[2];
   int         cnt[2];
   logic [7:0] cap[2];
   int         starts[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // expected frame from the frame rules, using plain integer arithmetic
   task automatic push_frame(input logic pll, input logic [2:0] s1, input logic [2:0] s2,
                             input logic ud, input logic [7:0] per);
      int g, h, t, o, p;
      p = int'(per);
      g = pll ? (int'(s2) + 2) % 8 : (int'(s1) + 6) % 8;
      h = p / 100;
      t = (p / 10) % 10;
      o = p % 10;
      for (int k = 0; k < 2; k++) begin
         logic [7:0] fr[$];
         fr = {};
         fr.push_back(8'(48 + g));
         fr.push_back(8'(48 + int'(ud)));
         if (k == 1 || h != 0) fr.push_back(8'(48 + h));
         if (k == 1 || h != 0 || t != 0) fr.push_back(8'(48 + t));
         fr.push_back(8'(48 + o));
         fr.push_back(STOP);
         foreach (fr[i]) begin
            if (k == 0) q0.push_back(fr[i]);
            else        q1.push_back(fr[i]);
         end
      end
   endtask

   task automatic set_req(input logic v, input logic pll, input logic [2:0] s1,
                          input logic [2:0] s2, input logic ud, input logic [7:0] per);
      rif0.report_valid = v;   rif1.report_valid = v;
      rif0.pll_to_update = pll; rif1.pll_to_update = pll;
      rif0.phasecounterselect_1 = s1; rif1.phasecounterselect_1 = s1;
      rif0.phasecounterselect_2 = s2; rif1.phasecounterselect_2 = s2;
      rif0.phaseupdown = ud;   rif1.phaseupdown = ud;
      rif0.periods_done = per; rif1.periods_done = per;
   endtask

   // raise a request, then scramble the inputs to show they were latched
   task automatic issue(input logic pll, input logic [2:0] s1, input logic [2:0] s2,
                        input logic ud, input logic [7:0] per, input logic expect_frame);
      @(posedge clk);
      set_req(1'b1, pll, s1, s2, ud, per);
      if (expect_frame) push_frame(pll, s1, s2, ud, per);
      repeat (2) @(posedge clk);
      set_req(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((rif0.busy || rif1.busy || q0.size() != 0 || q1.size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      total++;
      if (n >= 3000) begin
         bad++;
         $display("FAIL %s_timeout: busy=%0b/%0b pending=%0d/%0d, want idle and no pending bytes",
                  name, rif0.busy, rif1.busy, q0.size(), q1.size());
      end
      @(negedge clk);
      chk({name, "_busy0"}, 32'(rif0.busy), 32'd0);
      chk({name, "_busy1"}, 32'(rif1.busy), 32'd0);
   endtask

   // monitor and TX model for one instance; bsy is the tx_busy value the DUT last sampled
   task automatic mon(input int k, input logic st, input logic [7:0] d, input logic bsy);
      logic [7:0] exp;
      if (st) begin
         starts[k]++;
         total++;
         if (bsy) begin
            bad++;
            $display("FAIL start_while_busy[%0d]: tx_start=1 with tx_busy=1, want start withheld", k);
         end
         total++;
         if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_start[%0d]: byte %0h sent, want no start", k, d);
         end else begin
            exp = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (d !== exp) begin
               bad++;
               $display("FAIL frame_byte[%0d]: got %0h, want %0h", k, d, exp);
            end
         end
         mb[k]  = 1'b1;
         cnt[k] = (busy_len == 0) ? int'($urandom_range(1, 4)) : busy_len;
         cap[k] = d;
      end else if (mb[k]) begin
         total++;
         if (d !== cap[k]) begin
            bad++;
            $display("FAIL data_stable[%0d]: got %0h, want %0h", k, d, cap[k]);
         end
         cnt[k]--;
         if (cnt[k] == 0) mb[k] = 1'b0;
      end
   endtask

   initial begin
      mb[0] = 1'b0; mb[1] = 1'b0;
      starts[0] = 0; starts[1] = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            mb[0] = 1'b0; mb[1] = 1'b0;
         end else begin
            mon(0, rif0.tx_start, rif0.tx_data, rif0.tx_busy);
            mon(1, rif1.tx_start, rif1.tx_data, rif1.tx_busy);
         end
         rif0.tx_busy = mb[0] | hold;
         rif1.tx_busy = mb[1] | hold;
      end
   end

   task automatic chk_reset_outputs(input string name);
      chk({name, "_data0"},    32'(rif0.tx_data),  32'h00);
      chk({name, "_start0"},   32'(rif0.tx_start), 32'd0);
      chk({name, "_busy0"},    32'(rif0.busy),     32'd0);
      chk({name, "_overrun0"}, 32'(rif0.overrun),  32'd0);
      chk({name, "_data1"},    32'(rif1.tx_data),  32'h00);
      chk({name, "_overrun1"}, 32'(rif1.overrun),  32'd0);
   endtask

   initial begin
      int s0, s1;
      rst_n = 1'b0;
      hold = 1'b0;
      busy_len = 3;
      rif0.tx_busy = 1'b0; rif1.tx_busy = 1'b0;
      set_req(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0);
      repeat (3) @(posedge clk);
      #1 chk_reset_outputs("reset");
      @(posedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // basic frames: "11" + "5" + S, and "60255S"
      issue(1'b0, 3'b011, 3'b000, 1'b1, 8'd5, 1'b1);
      wait_idle("pll1_p5");
      chk("start_count_p5", 32'(starts[0]), 32'd4);
      issue(1'b1, 3'b000, 3'b100, 1'b0, 8'd255, 1'b1);
      wait_idle("pll2_p255");

      // digit boundaries, both suppression settings
      busy_len = 1;
      issue(1'b0, 3'b010, 3'b000, 1'b0, 8'd0, 1'b1);
      wait_idle("p0");
      issue(1'b1, 3'b111, 3'b111, 1'b1, 8'd100, 1'b1);
      wait_idle("p100");
      issue(1'b0, 3'b000, 3'b001, 1'b1, 8'd7, 1'b1);
      wait_idle("p7");
      chk("no_overrun0", 32'(rif0.overrun), 32'd0);
      chk("no_overrun1", 32'(rif1.overrun), 32'd0);

      // transmitter busy before the first byte: start must wait
      hold = 1'b1;
      busy_len = 2;
      s0 = starts[0]; s1 = starts[1];
      issue(1'b1, 3'b000, 3'b010, 1'b1, 8'd42, 1'b1);
      repeat (40) @(posedge clk);
      chk("held_starts0", 32'(starts[0]), 32'(s0));
      chk("held_starts1", 32'(starts[1]), 32'(s1));
      hold = 1'b0;
      wait_idle("held");

      // randomized frames against the model
      busy_len = 0;
      for (int i = 0; i < 20; i++) begin
         logic [7:0] per;
         case ($urandom_range(0, 3))
            0:       per = 8'($urandom_range(0, 9));
            1:       per = 8'($urandom_range(10, 99));
            2:       per = 8'($urandom_range(100, 255));
            default: per = 8'($urandom_range(0, 255));
         endcase
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), per, 1'b1);
         wait_idle("rand");
      end

      // second request while a frame is in flight: dropped, overrun sticky
      busy_len = 2;
      issue(1'b0, 3'b101, 3'b000, 1'b0, 8'd63, 1'b1);
      repeat (2) @(posedge clk);
      issue(1'b1, 3'b001, 3'b001, 1'b1, 8'd200, 1'b0);
      wait_idle("overrun");
      chk("overrun0", 32'(rif0.overrun), 32'd1);
      chk("overrun1", 32'(rif1.overrun), 32'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("overrun_sticky0", 32'(rif0.overrun), 32'd1);
      chk("overrun_sticky1", 32'(rif1.overrun), 32'd1);

      // reset during conversion abandons the frame
      issue(1'b1, 3'b000, 3'b011, 1'b1, 8'd255, 1'b1);
      @(posedge clk);
      rst_n = 1'b0;
      q0 = {}; q1 = {};
      repeat (2) @(posedge clk);
      #1 chk_reset_outputs("midreset");
      @(posedge clk);
      rst_n = 1'b1;
      s0 = starts[0]; s1 = starts[1];
      repeat (40) @(posedge clk);
      #1;
      chk("post_reset_starts0", 32'(starts[0]), 32'(s0));
      chk("post_reset_starts1", 32'(starts[1]), 32'(s1));
      chk("post_reset_busy0", 32'(rif0.busy), 32'd0);

      // normal operation resumes after reset
      issue(1'b0, 3'b100, 3'b000, 1'b0, 8'd19, 1'b1);
      wait_idle("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
